// File: rtl/shifter8_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// shifter8_ctrl_pkg
// Shared definitions for the multi-cycle 8-bit shifter controller:
//   - op_e    : operation codes (LSL, LSR, ASR, ROR)
//   - state_e : controller FSM state encoding (IDLE, SHIFT, DONE)
//   - step_of : per-cycle shift step, min(remaining, 3)
// ---------------------------------------------------------------------------
package shifter8_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_LSL = 2'b00,
    OP_LSR = 2'b01,
    OP_ASR = 2'b10,
    OP_ROR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

  // The combinational shifter handles at most 3 positions per cycle.
  function automatic logic [1:0] step_of(input logic [2:0] rem);
    logic [1:0] step;
    if (rem > 3'd3) begin
      step = 2'd3;
    end else begin
      step = rem[1:0];
    end
    return step;
  endfunction

endpackage

// File: rtl/shifter8.sv
// ---------------------------------------------------------------------------
// shifter8
// Purely combinational 8-bit shifter, 0..3 positions, no carry-out.
// Ports:
//   d_in  [7:0] operand
//   op    [1:0] 00 LSL, 01 LSR, 10 ASR (fill with d_in[7]), 11 ROR
//   shamt [1:0] shift distance 0..3
//   d_out [7:0] shifted result
// ---------------------------------------------------------------------------
module shifter8
  import shifter8_ctrl_pkg::*;
(
  input  logic [7:0] d_in,
  input  logic [1:0] op,
  input  logic [1:0] shamt,
  output logic [7:0] d_out
);

  logic [15:0] rot_s;

  // Rotate by shifting a doubled copy; the low byte is the rotated value.
  always_comb begin
    rot_s = {d_in, d_in} >> shamt;
  end

  // Select the requested shift flavour.
  always_comb begin
    d_out = 8'h00;
    case (op)
      OP_LSL:  d_out = d_in << shamt;
      OP_LSR:  d_out = d_in >> shamt;
      OP_ASR:  d_out = $signed(d_in) >>> shamt;
      OP_ROR:  d_out = rot_s[7:0];
      default: d_out = 8'h00;
    endcase
  end

endmodule

// File: rtl/shifter8_ctrl.sv
// ---------------------------------------------------------------------------
// shifter8_ctrl
// Multi-cycle 8-bit shift controller. A request accepted in IDLE is executed
// in SHIFT at up to 3 positions per cycle, then the result is published in
// d_out on entry to DONE, which lasts exactly one cycle.
// Ports:
//   clk         rising-edge clock
//   reset       synchronous active-high reset
//   start       request strobe, only honoured in IDLE
//   op    [1:0] 00 LSL, 01 LSR, 10 ASR, 11 ROR
//   shamt [2:0] total shift amount 0..7
//   d_in  [7:0] operand
//   d_out [7:0] result of the last completed operation (held otherwise)
//   busy        high while in SHIFT
//   done        one-cycle completion pulse (DONE state)
// ---------------------------------------------------------------------------
module shifter8_ctrl
  import shifter8_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] op,
  input  logic [2:0] shamt,
  input  logic [7:0] d_in,
  output logic [7:0] d_out,
  output logic       busy,
  output logic       done
);

  state_e     state_q, state_d;
  logic [7:0] wr_q, wr_d;
  logic [2:0] rem_q, rem_d;
  op_e        op_q, op_d;
  logic [7:0] d_out_q, d_out_d;

  logic [1:0] step_s;
  logic [2:0] rem_left_s;
  logic [7:0] sh_out_s;

  // Step size and the count left after this cycle's step.
  always_comb begin
    step_s     = step_of(rem_q);
    rem_left_s = rem_q - {1'b0, step_s};
  end

  shifter8 u_shifter8 (
    .d_in  (wr_q),
    .op    (op_q),
    .shamt (step_s),
    .d_out (sh_out_s)
  );

  // Next-state and datapath control; everything holds unless changed below.
  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    rem_d   = rem_q;
    op_d    = op_q;
    d_out_d = d_out_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          wr_d    = d_in;
          rem_d   = shamt;
          op_d    = op_e'(op);
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        wr_d  = sh_out_s;
        rem_d = rem_left_s;
        // Publish straight from the shifter so d_out only changes on DONE entry.
        if (rem_left_s == 3'd0) begin
          state_d = ST_DONE;
          d_out_d = sh_out_s;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      wr_q    <= 8'h00;
      rem_q   <= 3'd0;
      op_q    <= OP_LSL;
      d_out_q <= 8'h00;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      rem_q   <= rem_d;
      op_q    <= op_d;
      d_out_q <= d_out_d;
    end
  end

  // Status outputs are direct decodes of the state register.
  always_comb begin
    d_out = d_out_q;
    busy  = (state_q == ST_SHIFT);
    done  = (state_q == ST_DONE);
  end

endmodule
